// File: rtl/audio_vol_ramp.sv
// audio_vol_ramp: five-channel volume ramper that slews each current volume toward its host-written target once per sweep
// Ports: clk/reset_n (async active-low) clock and reset; sample_tick one pulse per audio sample;
//   wr_req/wr_ch/wr_vol host write held until wr_ack (valid channel) or wr_err (wr_ch > 4);
//   mute forces every effective target to zero; audio_vol1..5 current volumes; ramp_busy any channel off target.
module audio_vol_ramp #(
  parameter int RAMP_DIV = 4,
  parameter int STEP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_tick,
  input  logic       wr_req,
  input  logic [2:0] wr_ch,
  input  logic [7:0] wr_vol,
  output logic       wr_ack,
  output logic       wr_err,
  input  logic       mute,
  output logic [7:0] audio_vol1,
  output logic [7:0] audio_vol2,
  output logic [7:0] audio_vol3,
  output logic [7:0] audio_vol4,
  output logic [7:0] audio_vol5,
  output logic       ramp_busy
);
  typedef enum logic {H_IDLE, H_ACK} h_state_t;
  typedef enum logic {S_IDLE, S_SWEEP} s_state_t;
  localparam logic [7:0] DIV_TOP = 8'(RAMP_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  h_state_t h_q, h_d;
  s_state_t s_q, s_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] div_q, div_d;
  logic err_q, err_d;
  logic busy_q, busy_d;
  logic [7:0] tgt_q [5];
  logic [7:0] cur_q [5];
  logic [7:0] eff [5];
  logic [7:0] cur_sel, eff_sel, cur_nx;
  logic [8:0] up, dn;
  logic sweep_start, wr_en;
  always_comb begin
    sweep_start = sample_tick && div_q == DIV_TOP;
    div_d = sample_tick ? (sweep_start ? 8'd0 : div_q + 8'd1) : div_q;
    wr_en = h_q == H_IDLE && wr_req;
    h_d = wr_en ? H_ACK : (h_q == H_ACK && !wr_req) ? H_IDLE : h_q;
    err_d = wr_en ? wr_ch > 3'd4 : err_q;
    s_d = s_q == S_IDLE ? (sweep_start ? S_SWEEP : S_IDLE) : (idx_q == 3'd4 ? S_IDLE : S_SWEEP);
    idx_d = (s_q == S_SWEEP && idx_q != 3'd4) ? idx_q + 3'd1 : 3'd0;
    cur_sel = '0;
    eff_sel = '0;
    busy_d = 1'b0;
    for (int n = 0; n < 5; n++) begin
      eff[n] = mute ? 8'd0 : tgt_q[n];
      busy_d = busy_d | (cur_q[n] != eff[n]);
      if (idx_q == 3'(n)) begin
        cur_sel = cur_q[n];
        eff_sel = eff[n];
      end
    end
    // distances in 9 bits so a step can never carry past 255 or borrow below 0
    up = {1'b0, eff_sel} - {1'b0, cur_sel};
    dn = {1'b0, cur_sel} - {1'b0, eff_sel};
    cur_nx = cur_sel < eff_sel ? 8'({1'b0, cur_sel} + (up < STEP9 ? up : STEP9)) :
             cur_sel > eff_sel ? 8'({1'b0, cur_sel} - (dn < STEP9 ? dn : STEP9)) : cur_sel;
  end
  // tgt is written and the swept channel stepped on the same edge, so a colliding write lands after that step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= H_IDLE;
      s_q <= S_IDLE;
      idx_q <= '0;
      div_q <= '0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      for (int n = 0; n < 5; n++) begin
        tgt_q[n] <= '0;
        cur_q[n] <= '0;
      end
    end else begin
      h_q <= h_d;
      s_q <= s_d;
      idx_q <= idx_d;
      div_q <= div_d;
      err_q <= err_d;
      busy_q <= busy_d;
      for (int n = 0; n < 5; n++) begin
        if (wr_en && wr_ch == 3'(n)) tgt_q[n] <= wr_vol;
        if (s_q == S_SWEEP && idx_q == 3'(n)) cur_q[n] <= cur_nx;
      end
    end
  end
  assign wr_ack = h_q == H_ACK && wr_req && !err_q;
  assign wr_err = h_q == H_ACK && wr_req && err_q;
  assign ramp_busy = busy_q;
  assign audio_vol1 = cur_q[0];
  assign audio_vol2 = cur_q[1];
  assign audio_vol3 = cur_q[2];
  assign audio_vol4 = cur_q[3];
  assign audio_vol5 = cur_q[4];
endmodule

// File: tb/tb_audio_vol_ramp.sv
// tb_audio_vol_ramp: two parameterisations of audio_vol_ramp against a per-sweep volume model
module tb_audio_vol_ramp;
  logic clk = 0, reset_n = 0, sample_tick = 0, wr_req = 0, mute = 0;
  logic [2:0] wr_ch = 0;
  logic [7:0] wr_vol = 0;
  logic ack_a, err_a, busy_a, ack_b, err_b, busy_b;
  logic [7:0] va [5];
  logic [7:0] vb [5];
  int checks = 0, fails = 0;
  int m_tgt [5];
  int ca [5];
  int cb [5];
  int cnt = 0;
  always #5 clk = ~clk;
  audio_vol_ramp ua (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .wr_req(wr_req), .wr_ch(wr_ch),
    .wr_vol(wr_vol), .wr_ack(ack_a), .wr_err(err_a), .mute(mute), .audio_vol1(va[0]),
    .audio_vol2(va[1]), .audio_vol3(va[2]), .audio_vol4(va[3]), .audio_vol5(va[4]), .ramp_busy(busy_a));
  audio_vol_ramp #(.RAMP_DIV(2), .STEP(16)) ub (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .wr_req(wr_req), .wr_ch(wr_ch),
    .wr_vol(wr_vol), .wr_ack(ack_b), .wr_err(err_b), .mute(mute), .audio_vol1(vb[0]),
    .audio_vol2(vb[1]), .audio_vol3(vb[2]), .audio_vol4(vb[3]), .audio_vol5(vb[4]), .ramp_busy(busy_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int stepf(input int c, input int e, input int s);
    if (c < e) return (e - c > s) ? c + s : e;
    if (c > e) return (c - e > s) ? c - s : e;
    return c;
  endfunction
  function automatic int effm(input int n);
    return mute ? 0 : m_tgt[n];
  endfunction
  function automatic logic busy_exp(input bit use_b);
    for (int n = 0; n < 5; n++) if ((use_b ? cb[n] : ca[n]) != effm(n)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_sweep();
    cnt++;
    for (int n = 0; n < 5; n++) begin
      if (cnt % 4 == 0) ca[n] = stepf(ca[n], effm(n), 1);
      if (cnt % 2 == 0) cb[n] = stepf(cb[n], effm(n), 16);
    end
  endtask
  task automatic model_reset();
    cnt = 0;
    for (int n = 0; n < 5; n++) begin
      m_tgt[n] = 0;
      ca[n] = 0;
      cb[n] = 0;
    end
  endtask
  task automatic check_all();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("a_vol%0d", n + 1), 32'(va[n]), 32'(ca[n]));
      chk($sformatf("b_vol%0d", n + 1), 32'(vb[n]), 32'(cb[n]));
    end
    chk("a_busy", 32'(busy_a), 32'(busy_exp(0)));
    chk("b_busy", 32'(busy_b), 32'(busy_exp(1)));
  endtask
  task automatic check_zero(input string tag);
    for (int n = 0; n < 5; n++) begin
      chk({tag, "_a_vol"}, 32'(va[n]), 0);
      chk({tag, "_b_vol"}, 32'(vb[n]), 0);
    end
    chk({tag, "_acks"}, 32'({ack_a, err_a, ack_b, err_b}), 0);
    chk({tag, "_busy"}, 32'({busy_a, busy_b}), 0);
  endtask
  task automatic tick();
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0;
    repeat (7) @(negedge clk);
    model_sweep();
    check_all();
  endtask
  task automatic write(input int ch, input int vol, input int hold);
    @(negedge clk);
    wr_req = 1;
    wr_ch = 3'(ch);
    wr_vol = 8'(vol);
    if (ch <= 4) m_tgt[ch] = vol;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("ack_a", 32'(ack_a), 32'(ch <= 4));
      chk("err_a", 32'(err_a), 32'(ch > 4));
      chk("ack_b", 32'(ack_b), 32'(ch <= 4));
      chk("err_b", 32'(err_b), 32'(ch > 4));
      wr_vol = ~8'(vol);
    end
    wr_req = 0;
    #1 chk("ack_drop", 32'({ack_a, err_a, ack_b, err_b}), 0);
  endtask
  task automatic settle();
    for (int i = 0; i < 400 && (busy_exp(0) || busy_exp(1)); i++) tick();
  endtask
  task automatic align_a();
    while ((cnt + 1) % 4 != 0) tick();
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1;
    write(0, 3, 1);
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t % 4 == 0) chk("ramp_up_vol1", 32'(va[0]), t == 4 ? 1 : t == 8 ? 2 : 3);
      if (t == 8) chk("ramp_busy_hi", 32'(busy_a), 1);
      if (t == 12) chk("ramp_busy_lo", 32'(busy_a), 0);
    end
    write(2, 5, 1);
    tick();
    tick();
    chk("clamp_b_5", 32'(vb[2]), 5);
    write(2, 0, 1);
    tick();
    tick();
    chk("clamp_b_0", 32'(vb[2]), 0);
    write(2, 8'hFA, 1);
    repeat (32) tick();
    chk("clamp_b_fa", 32'(vb[2]), 32'hFA);
    write(2, 8'hFF, 1);
    tick();
    tick();
    chk("clamp_b_ff", 32'(vb[2]), 32'hFF);
    write(1, 8'h80, 10);
    write(6, 8'h55, 3);
    for (int n = 0; n < 5; n++) write(n, 8'h20, 1);
    settle();
    for (int n = 0; n < 5; n++) chk("pre_mute", 32'(va[n]), 32'h20);
    @(negedge clk) mute = 1;
    settle();
    for (int n = 0; n < 5; n++) chk("muted", 32'(va[n]), 0);
    @(negedge clk) mute = 0;
    settle();
    for (int n = 0; n < 5; n++) chk("unmuted", 32'(va[n]), 32'h20);
    align_a();
    @(negedge clk) sample_tick = 1;
    @(negedge clk);
    sample_tick = 0;
    wr_req = 1;
    wr_ch = 0;
    wr_vol = 8'h28;
    @(negedge clk);
    chk("coll_ack", 32'(ack_a), 1);
    wr_req = 0;
    repeat (6) @(negedge clk);
    model_sweep();
    m_tgt[0] = 8'h28;
    check_all();
    chk("coll_old_tgt", 32'(va[0]), 32'h20);
    align_a();
    tick();
    chk("coll_new_tgt", 32'(va[0]), 32'h21);
    align_a();
    @(negedge clk) sample_tick = 1;
    @(negedge clk) sample_tick = 0;
    @(negedge clk);
    reset_n = 0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk) reset_n = 1;
    check_all();
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) tick();
      else if (r < 9) write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
      else @(negedge clk) mute = ~mute;
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/audio_vol_ramp.md
AUDIO_VOL_RAMP -- requirements
Module: audio_vol_ramp

Interface
REQ-001 The block SHALL have parameter RAMP_DIV, default 4: number of sample_tick pulses between ramp sweeps, legal range 1..255.
REQ-002 The block SHALL have parameter STEP, default 1: maximum volume change per channel per sweep, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sample_tick, input, 1 bit: one-cycle pulse per audio sample, minimum spacing 6 cycles.
REQ-006 The block SHALL have port wr_req, input, 1 bit: host write request, held high until wr_ack is seen.
REQ-007 The block SHALL have port wr_ch, input, 3 bits: target channel, 0..4 valid.
REQ-008 The block SHALL have port wr_vol, input, 8 bits: target volume, unsigned.
REQ-009 The block SHALL have port wr_ack, output, 1 bit: write accepted.
REQ-010 The block SHALL have port wr_err, output, 1 bit: write rejected because wr_ch > 4.
REQ-011 The block SHALL have port mute, input, 1 bit: level-sensitive global mute.
REQ-012 The block SHALL have ports audio_vol1..audio_vol5, output, 8 bits each: current volumes that drive the mixer volume inputs.
REQ-013 The block SHALL have port ramp_busy, output, 1 bit: at least one channel is not at its effective target.

Function
REQ-014 The block SHALL hold per-channel target registers tgt[0..4] and current registers cur[0..4], all 8 bits; audio_volN SHALL equal cur[N-1] directly as a register output.
REQ-015 The effective target eff[n] SHALL be 0 while mute=1 and tgt[n] otherwise; mute SHALL NOT modify tgt.
REQ-016 The write handshake FSM SHALL have states H_IDLE and H_ACK, reset to H_IDLE.
REQ-017 In H_IDLE with wr_req=1, the block SHALL latch the write (tgt[wr_ch] <= wr_vol if wr_ch <= 4) and enter H_ACK on the next edge.
REQ-018 In H_ACK, wr_ack SHALL be 1 for a valid channel, or wr_err SHALL be 1 for an invalid channel; the output SHALL stay high while wr_req=1.
REQ-019 The block SHALL return to H_IDLE on the first cycle with wr_req=0; a held wr_req SHALL NOT cause a second write.
REQ-020 An invalid-channel write SHALL leave every tgt and cur unchanged.
REQ-021 The tick divider SHALL be an 8-bit counter that increments on each sample_tick; when it reaches RAMP_DIV-1 it SHALL wrap to 0 and raise sweep_start for one cycle.
REQ-022 The sweep FSM SHALL have states S_IDLE and S_SWEEP, with a 3-bit channel index idx.
REQ-023 On sweep_start in S_IDLE, the sweep FSM SHALL enter S_SWEEP with idx=0.
REQ-024 In S_SWEEP, the block SHALL update one channel per cycle (idx 0,1,2,3,4), then return to S_IDLE after idx=4; a sweep SHALL take exactly 5 cycles.
REQ-025 The step rule SHALL be: if cur<eff, cur += min(STEP, eff-cur); if cur>eff, cur -= min(STEP, cur-eff); otherwise hold. Comparisons SHALL use 9-bit unsigned arithmetic, so there is no overshoot and no wrap past 0 or 255.
REQ-026 A sweep_start arriving while in S_SWEEP SHALL be ignored; the divider SHALL keep counting.
REQ-027 A host write to the channel being swept in the same cycle SHALL update tgt, and that cycle's step SHALL use the old tgt.
REQ-028 A mute change SHALL take effect at the next channel evaluated.
REQ-029 ramp_busy SHALL be registered and equal OR over n of (cur[n] != eff[n]), evaluated one cycle late.

Reset
REQ-030 While reset_n=0, the block SHALL asynchronously clear tgt, cur, the divider, and idx, and force the FSMs to H_IDLE and S_IDLE.
REQ-031 While reset_n=0, all outputs SHALL be 0: audio_vol1..5=0x00, wr_ack=0, wr_err=0, ramp_busy=0.
REQ-032 On reset release, the first sweep SHALL follow the RAMP_DIV-th sample_tick.
REQ-033 Reset mid-sweep or mid-handshake SHALL abort the operation with no partial write surviving.

Verification
REQ-034 Ramp up: RAMP_DIV=4, STEP=1, write ch0=0x03, then 16 sample_ticks -> audio_vol1 reads 1,2,3,3 after ticks 4,8,12,16; ramp_busy falls after tick 12.
REQ-035 Clamp: STEP=16, cur ch2=0x05, write 0x00, one sweep -> audio_vol3=0x00 (not 0xF5); 0xFA toward 0xFF -> 0xFF.
REQ-036 Handshake: hold wr_req for 10 cycles with ch=1, vol=0x80 -> wr_ack high from cycle 2 until wr_req drops, one write only; wr_ch=6 -> wr_err high, all tgt unchanged.
REQ-037 Mute: all channels at 0x20, mute=1 -> outputs step down to 0x00 and tgt is preserved; mute=0 -> outputs return to 0x20.
REQ-038 Collision: sweep_start during S_SWEEP is ignored (cur changes by at most STEP per channel); a write to the active idx applies at the next sweep.
REQ-039 Reset: assert reset_n=0 mid-sweep -> all outputs 0x00 immediately, without waiting for a clk edge.
